// File: rtl/mcu_timer.sv
// ============================================================================
// Module   : mcu_timer
// Purpose  : Bus-mapped 32-bit timer with prescaler, compare match and irq.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mcu_timer #(
  parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  addr,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [5:0] c_IDX_CTRL     = 6'd0;
  localparam logic [5:0] c_IDX_PRESCALE = 6'd1;
  localparam logic [5:0] c_IDX_COUNT    = 6'd2;
  localparam logic [5:0] c_IDX_COMPARE  = 6'd3;
  localparam logic [5:0] c_IDX_STATUS   = 6'd4;

  logic        r_en;
  logic        r_reload;
  logic        r_ie;
  logic [15:0] r_prescale;
  logic [15:0] r_pcnt;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_match;

  logic [5:0]  w_idx;
  logic        w_wr_ctrl;
  logic        w_wr_pre;
  logic        w_wr_count;
  logic        w_wr_cmp;
  logic        w_wr_status;
  logic        w_tick;
  logic        w_hit;
  logic        w_rd_unused;

  assign w_idx       = addr[7:2];
  assign w_wr_ctrl   = wr && (w_idx == c_IDX_CTRL);
  assign w_wr_pre    = wr && (w_idx == c_IDX_PRESCALE);
  assign w_wr_count  = wr && (w_idx == c_IDX_COUNT);
  assign w_wr_cmp    = wr && (w_idx == c_IDX_COMPARE);
  assign w_wr_status = wr && (w_idx == c_IDX_STATUS);
  assign w_rd_unused = rd;

  assign w_tick = r_en && (r_pcnt == r_prescale);
  // A COUNT write in a tick cycle suppresses the match evaluation entirely.
  assign w_hit  = w_tick && !w_wr_count && (r_count == r_compare);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en       <= 1'b0;
      r_reload   <= 1'b0;
      r_ie       <= 1'b0;
      r_prescale <= 16'd0;
      r_compare  <= RESET_COMPARE;
    end else begin
      if (w_wr_ctrl) begin
        r_en     <= wdata[0];
        r_reload <= wdata[1];
        r_ie     <= wdata[2];
      end
      if (w_wr_pre) begin
        r_prescale <= wdata[15:0];
      end
      if (w_wr_cmp) begin
        r_compare <= wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcnt <= 16'd0;
    end else if (w_wr_ctrl || w_wr_pre || !r_en || w_tick) begin
      r_pcnt <= 16'd0;
    end else begin
      r_pcnt <= r_pcnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 32'd0;
    end else if (w_wr_count) begin
      r_count <= wdata;
    end else if (w_tick) begin
      r_count <= (w_hit && r_reload) ? 32'd0 : r_count + 32'd1;
    end
  end

  // Setting the flag takes priority over a same-cycle W1C.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_match <= 1'b0;
    end else if (w_hit) begin
      r_match <= 1'b1;
    end else if (w_wr_status && wdata[0]) begin
      r_match <= 1'b0;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (w_idx)
      c_IDX_CTRL:     rdata = {29'd0, r_ie, r_reload, r_en};
      c_IDX_PRESCALE: rdata = {16'd0, r_prescale};
      c_IDX_COUNT:    rdata = r_count;
      c_IDX_COMPARE:  rdata = r_compare;
      c_IDX_STATUS:   rdata = {31'd0, r_match};
      default:        rdata = 32'd0;
    endcase
  end

  assign irq = r_match & r_ie;

endmodule

`default_nettype wire

// File: tb/tb_mcu_timer.sv
// ============================================================================
// Module   : tb_mcu_timer
// Purpose  : Scoreboard bench for mcu_timer against a behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mcu_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  addr;
  logic        rd;
  logic        wr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  always #5 clk = ~clk;

  mcu_timer #(.RESET_COMPARE(32'hFFFF_FFFF)) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .rd    (rd),
    .wr    (wr),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  typedef struct {
    logic [7:0]  a;
    logic [31:0] rdata;
    logic        irq;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference state: the prescaler is modelled as cycles elapsed since the
  // last restart, ticking whenever that count lands on P modulo P+1.
  bit          m_en, m_reload, m_ie, m_match;
  int unsigned m_p;
  int unsigned m_elapsed;
  bit [31:0]   m_count, m_cmp;

  function automatic void m_reset();
    m_en = 0; m_reload = 0; m_ie = 0; m_match = 0;
    m_p = 0; m_elapsed = 0; m_count = 0; m_cmp = 32'hFFFF_FFFF;
  endfunction

  function automatic bit m_tick();
    return m_en && ((m_elapsed % (m_p + 1)) == m_p);
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a / 4)
      0:       return {29'd0, m_ie, m_reload, m_en};
      1:       return m_p;
      2:       return m_count;
      3:       return m_cmp;
      4:       return {31'd0, m_match};
      default: return 32'd0;
    endcase
  endfunction

  function automatic void m_step(input bit w, input logic [7:0] a, input logic [31:0] d);
    int  reg_n;
    bit  tick, hit;
    reg_n = a / 4;
    tick  = m_tick();
    hit   = tick && !(w && reg_n == 2) && (m_count == m_cmp);
    if ((w && (reg_n == 0 || reg_n == 1)) || !m_en) m_elapsed = 0;
    else m_elapsed = m_elapsed + 1;
    if (w && reg_n == 2) m_count = d;
    else if (tick) m_count = (hit && m_reload) ? 32'd0 : m_count + 32'd1;
    if (hit) m_match = 1;
    else if (w && reg_n == 4 && d[0]) m_match = 0;
    if (w && reg_n == 0) begin m_en = d[0]; m_reload = d[1]; m_ie = d[2]; end
    if (w && reg_n == 1) m_p = d[15:0];
    if (w && reg_n == 3) m_cmp = d;
  endfunction

  task automatic cycle(input logic r, input logic w, input logic [7:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    rst = 0; rd = r; wr = w; addr = a; wdata = d;
    q.push_back('{a: a, rdata: m_read(a), irq: m_match & m_ie});
    m_step(w, a, d);
  endtask

  task automatic rd_cycle(input logic [7:0] a);
    cycle(1'b1, 1'b0, a, 32'd0);
  endtask

  task automatic wr_cycle(input logic [7:0] a, input logic [31:0] d);
    cycle(1'b0, 1'b1, a, d);
  endtask

  // Reset asserted between edges; every listed offset is read while held.
  task automatic reset_readback();
    logic [7:0] offs [7];
    offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'hFC};
    foreach (offs[i]) begin
      @(posedge clk);
      #1;
      rst = 1; rd = 1; wr = 0; addr = offs[i]; wdata = 32'd0;
      m_reset();
      q.push_back('{a: offs[i], rdata: m_read(offs[i]), irq: 1'b0});
    end
  endtask

  task automatic timeout(input string what);
    errors++;
    $display("FAIL wait_%s: bound expired, condition got=0 required=1", what);
  endtask

  exp_t e;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      checks += 2;
      if (rdata !== e.rdata) begin
        errors++;
        $display("FAIL rdata@%02h: got=%08h required=%08h", e.a, rdata, e.rdata);
      end
      if (irq !== e.irq) begin
        errors++;
        $display("FAIL irq@%02h: got=%0b required=%0b", e.a, irq, e.irq);
      end
    end
  end

  initial begin
    bit done;
    rst = 1; rd = 0; wr = 0; addr = 8'h00; wdata = 32'd0;
    m_reset();
    reset_readback();

    // Reset mid-count with COUNT=0x55.
    wr_cycle(8'h08, 32'h55);
    wr_cycle(8'h00, 32'h1);
    repeat (3) rd_cycle(8'h08);
    reset_readback();

    // Prescaled count.
    wr_cycle(8'h04, 32'd3);
    wr_cycle(8'h00, 32'h1);
    repeat (42) rd_cycle(8'h08);

    // Auto-reload with interrupt, then W1C.
    wr_cycle(8'h00, 32'h0);
    wr_cycle(8'h04, 32'd0);
    wr_cycle(8'h08, 32'd0);
    wr_cycle(8'h0C, 32'd5);
    wr_cycle(8'h00, 32'h7);
    repeat (7) rd_cycle(8'h08);
    rd_cycle(8'h10);
    wr_cycle(8'h10, 32'h1);
    rd_cycle(8'h10);

    // Wrap without reload.
    wr_cycle(8'h00, 32'h0);
    wr_cycle(8'h10, 32'h1);
    wr_cycle(8'h08, 32'hFFFF_FFFE);
    wr_cycle(8'h0C, 32'h10);
    wr_cycle(8'h00, 32'h1);
    repeat (3) rd_cycle(8'h08);
    rd_cycle(8'h10);

    // COUNT write on a tick cycle, then W1C coinciding with a match.
    wr_cycle(8'h08, 32'h100);
    rd_cycle(8'h08);
    rd_cycle(8'h08);
    wr_cycle(8'h0C, 32'h108);
    wr_cycle(8'h00, 32'h5);
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (m_tick() && m_count == m_cmp) begin
        cycle(1'b1, 1'b1, 8'h10, 32'h1);
        done = 1;
      end else begin
        rd_cycle(8'h08);
      end
    end
    if (!done) timeout("match");
    rd_cycle(8'h10);
    wr_cycle(8'h10, 32'h1);

    // Disable mid-prescale at pcnt=5, then re-enable.
    wr_cycle(8'h0C, 32'hFFFF_FFFF);
    wr_cycle(8'h04, 32'd7);
    wr_cycle(8'h00, 32'h1);
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (m_en && m_elapsed % 8 == 5) begin
        wr_cycle(8'h00, 32'h0);
        done = 1;
      end else begin
        rd_cycle(8'h08);
      end
    end
    if (!done) timeout("pcnt5");
    repeat (6) rd_cycle(8'h08);
    wr_cycle(8'h00, 32'h1);
    repeat (20) rd_cycle(8'h08);

    // Randomised traffic with writes biased toward interesting values.
    for (int n = 0; n < 600; n++) begin
      int unsigned sel, kind;
      logic [7:0]  a;
      logic [31:0] d;
      sel  = $urandom_range(0, 6);
      a    = (sel < 5) ? 8'(sel * 4) : 8'($urandom_range(5, 63) * 4);
      a    = a | 8'($urandom_range(0, 3));
      kind = $urandom_range(0, 9);
      case (sel)
        0:       d = $urandom_range(0, 7) | (kind < 7 ? 32'h1 : 32'h0) | ($urandom() & 32'hFFFF_FFF8);
        1:       d = $urandom_range(0, 3) | ($urandom() & 32'hFFFF_0000);
        2:       d = (kind < 6) ? m_cmp - $urandom_range(0, 6) : $urandom();
        3:       d = m_count + $urandom_range(0, 8);
        default: d = $urandom();
      endcase
      if (n % 97 == 50) begin
        reset_readback();
      end else if (kind < 3) begin
        cycle(1'($urandom_range(0, 1)), 1'b1, a, d);
      end else begin
        rd_cycle(a);
      end
    end

    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending got=%0d required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mcu_timer.md
# mcu_timer

Memory-mapped 32-bit timer peripheral on the simple peripheral bus, in the timer slot (address window 0x2xx) behind the AXI4-Lite peripheral bridge. It has a 16-bit prescaler, a free-running or auto-reload 32-bit counter, a compare register, a sticky match flag, and a level interrupt to the core. The bridge captures `timer_rdata` in the same cycle it asserts `timer_rd`, so read data is combinational from `addr`.

## Interface
- `RESET_COMPARE`, default 32'hFFFF_FFFF: reset value of COMPARE.
- `clk`, in, 1: sole clock; all state updates on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `addr`, in, 8: register byte offset. `addr[1:0]` is ignored; only word accesses are supported.
- `rd`, in, 1: read strobe, 1 cycle. Has no side effects; informational only.
- `wr`, in, 1: write strobe, 1 cycle. Full 32-bit word; no byte strobes.
- `wdata`, in, 32: write data, qualified by `wr`.
- `rdata`, out, 32: combinational read data for `addr`, valid every cycle.
- `irq`, out, 1: level interrupt, `STATUS.match & CTRL.ie`, decoded from registers (no combinational path from bus inputs).

## Operation
- Register map:
  - 0x00 CTRL: [0] en, [1] reload, [2] ie, others read 0.
  - 0x04 PRESCALE: [15:0] P, upper bits read 0.
  - 0x08 COUNT: [31:0].
  - 0x0C COMPARE: [31:0].
  - 0x10 STATUS: [0] match. Write-1-to-clear; writing 0 has no effect.
- Unmapped offsets (including 0x14–0xFC) read 0; writes to them are ignored.
- Prescaler: internal 16-bit `pcnt`.
  - `tick` = en && (`pcnt` == P).
  - While en: `pcnt` <= tick ? 0 : `pcnt`+1.
  - While !en: `pcnt` <= 0.
  - Any write to PRESCALE or CTRL also forces `pcnt` <= 0.
- Counter, on tick:
  - If COUNT == COMPARE: set match; COUNT <= reload ? 0 : COUNT+1.
  - Otherwise: COUNT <= COUNT+1.
  - Arithmetic is modulo 2^32: 0xFFFF_FFFF+1 wraps to 0 with no flag.
- The match comparison uses the pre-update COUNT value.
- With P=0, the counter advances every cycle. With P=k, it advances every k+1 cycles.
- Simultaneous events:
  - COUNT write with tick: the write wins; no increment and no match evaluation that cycle.
  - STATUS W1C with a match set in the same cycle: set wins, so match stays 1.
  - COMPARE write with tick: the compare uses the old COMPARE value.
  - CTRL write that clears en: takes effect at the edge; no tick occurs in the cycle after.
- `rd` and `wr` together (not produced by the bridge): the write is performed. `rdata` shows the pre-write value during that cycle.

## Timing
- Reset values, asynchronous on `rst` high:
  - CTRL=0, PRESCALE=0, COUNT=0, COMPARE=`RESET_COMPARE`, STATUS=0, `pcnt`=0.
  - Outputs: `irq`=0; `rdata` = decode of the reset registers (0 for all offsets except 0x0C).
- Reset asserted mid-count clears all state immediately. Counting resumes only after software sets en again.
- Register write latency: `wr` in cycle N; the new value is readable in cycle N+1.
- Enable to first increment (P=0):
  - CTRL.en written in cycle N.
  - tick in cycle N+1.
  - COUNT reads 1 in cycle N+2.
- Match to interrupt:
  - tick with COUNT==COMPARE in cycle M.
  - STATUS.match=1 and `irq`=1 (if ie) in cycle M+1.
- W1C in cycle N: `irq` deasserts in cycle N+1.
- `rdata` has zero-cycle latency: it is combinational from `addr` and register state, so the bridge's same-cycle capture is valid.

## Test plan
- Reset/readback: assert `rst` mid-run with COUNT=0x55.
  - Required: all offsets read their reset values; COMPARE reads 0xFFFF_FFFF; 0x14 reads 0; `irq`=0.
- Prescaled count: write PRESCALE=3, CTRL=0x1, then wait 40 cycles after the CTRL write cycle.
  - Required: COUNT reads 10. Increments are exactly 4 cycles apart.
- Auto-reload match and irq: write COMPARE=5, CTRL=0x7, P=0.
  - Required: COUNT sequence 1,2,3,4,5,0,1.
  - Required: match=1 and `irq`=1 the cycle after the tick that saw COUNT==5.
  - Then write STATUS=0x1. Required: `irq`=0 the next cycle.
- Wrap without reload: write COUNT=0xFFFF_FFFE, COMPARE=0x10, CTRL=0x1.
  - Required: COUNT goes 0xFFFF_FFFF then 0x0; match stays 0.
- Collisions, P=0, en=1:
  - Write COUNT=0x100 on a tick cycle. Required: next read is 0x100, then 0x101.
  - Issue a W1C on the same cycle as a match. Required: match remains 1.
- Disable mid-prescale: P=7, clear en when `pcnt`=5, re-enable.
  - Required: COUNT is frozen while disabled. The first increment comes 8 cycles after re-enable, because `pcnt` restarts at 0.
